// File: rtl/jtframe_6809_romcache.sv
// Two-line, 32-bit-word ROM fetch cache between the 6809 ROM decoder and the SDRAM ROM port.
// Define JTFRAME_ROMCACHE_PREFETCH_EN to prefetch word n+1 after each demand fill of word n.
module jtframe_6809_romcache #(
    parameter int AW          = 16,
    parameter int FLUSH_ON_CS = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_cs,
    input  logic          flush,
    output logic          rom_ok,
    output logic [7:0]    cpu_dout,
    output logic [AW-3:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [31:0]   sdram_data
);
    localparam int TW = AW - 2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    valid_q, valid_d;
    logic [TW-1:0] tag_q [2];
    logic [TW-1:0] tag_d [2];
    logic [31:0]   data_q [2];
    logic [31:0]   data_d [2];
    logic          lru_q, lru_d;
    logic          victim_q, victim_d;
    logic          discard_q, discard_d;
    logic          sdram_req_q, sdram_req_d;
    logic [TW-1:0] fetch_addr_q, fetch_addr_d;

    logic [TW-1:0] cpu_tag;
    logic          hit0, hit1, miss, fill, keep;
    logic [31:0]   hit_word;

`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
    logic          pf_pending_q, pf_pending_d;
    logic [TW-1:0] pf_addr_q, pf_addr_d;
    logic          pf_victim_q, pf_victim_d;
    logic          is_pf_q, is_pf_d;
    logic          pf_held;
`endif

    // FLUSH_ON_CS is reserved; no logic depends on it.
    if (FLUSH_ON_CS != 0) begin : g_flush_on_cs_reserved
    end

    assign cpu_tag    = cpu_addr[AW-1:2];
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = fetch_addr_q;

    always_comb begin
        hit0     = cpu_cs && valid_q[0] && (tag_q[0] == cpu_tag);
        hit1     = cpu_cs && valid_q[1] && (tag_q[1] == cpu_tag);
        rom_ok   = hit0 || hit1;
        miss     = cpu_cs && !rom_ok;
        hit_word = hit1 ? data_q[1] : data_q[0];
        cpu_dout = 8'h00;
        if (rom_ok) begin
            case (cpu_addr[1:0])
                2'd0:    cpu_dout = hit_word[7:0];
                2'd1:    cpu_dout = hit_word[15:8];
                2'd2:    cpu_dout = hit_word[23:16];
                default: cpu_dout = hit_word[31:24];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        lru_d        = lru_q;
        victim_d     = victim_q;
        discard_d    = discard_q;
        sdram_req_d  = sdram_req_q;
        fetch_addr_d = fetch_addr_q;
        fill         = 1'b0;
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
        pf_pending_d = pf_pending_q;
        pf_addr_d    = pf_addr_q;
        pf_victim_d  = pf_victim_q;
        is_pf_d      = is_pf_q;
        pf_held      = (valid_q[0] && (tag_q[0] == pf_addr_q)) ||
                       (valid_q[1] && (tag_q[1] == pf_addr_q));
`endif

        if (hit0) lru_d = 1'b1;
        else if (hit1) lru_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    fetch_addr_d = cpu_tag;
                    victim_d     = lru_q;
                    discard_d    = 1'b0;
                    sdram_req_d  = 1'b1;
                    state_d      = ST_REQ;
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
                    is_pf_d      = 1'b0;
`endif
                end
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
                else if (pf_pending_q && !flush) begin
                    pf_pending_d = 1'b0;
                    if (!pf_held) begin
                        fetch_addr_d = pf_addr_q;
                        victim_d     = pf_victim_q;
                        discard_d    = 1'b0;
                        sdram_req_d  = 1'b1;
                        state_d      = ST_REQ;
                        is_pf_d      = 1'b1;
                    end
                end
`endif
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (sdram_dok) begin
                        fill    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_dok) begin
                    fill    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush && (state_q != ST_IDLE)) discard_d = 1'b1;
        if (flush) valid_d = '0;

        // A flush in the fill cycle discards too; the fetch still ends normally.
        keep = fill && !discard_q && !flush;
        if (fill) lru_d = ~victim_q;
        if (keep) begin
            valid_d[victim_q] = 1'b1;
            tag_d[victim_q]   = fetch_addr_q;
            data_d[victim_q]  = sdram_data;
        end

`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
        if (keep && !is_pf_q) begin
            pf_pending_d = 1'b1;
            pf_addr_d    = fetch_addr_q + 1'b1;
            pf_victim_d  = ~victim_q;
        end
        if (flush) pf_pending_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            lru_q        <= 1'b0;
            victim_q     <= 1'b0;
            discard_q    <= 1'b0;
            sdram_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
            pf_pending_q <= 1'b0;
            pf_addr_q    <= '0;
            pf_victim_q  <= 1'b0;
            is_pf_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            lru_q        <= lru_d;
            victim_q     <= victim_d;
            discard_q    <= discard_d;
            sdram_req_q  <= sdram_req_d;
            fetch_addr_q <= fetch_addr_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
            pf_pending_q <= pf_pending_d;
            pf_addr_q    <= pf_addr_d;
            pf_victim_q  <= pf_victim_d;
            is_pf_q      <= is_pf_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtframe_6809_romcache.sv
// Directed bench for jtframe_6809_romcache; the SDRAM side is driven step by step.
// The prefetch scenario runs only when JTFRAME_ROMCACHE_PREFETCH_EN is defined.
module tb_jtframe_6809_romcache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_cs = 1'b0;
    logic        flush = 1'b0;
    logic        rom_ok;
    logic [7:0]  cpu_dout;
    logic [13:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic        sdram_dok = 1'b0;
    logic [31:0] sdram_data = '0;

    int checks = 0;
    int errors = 0;

    jtframe_6809_romcache #(.AW(16), .FLUSH_ON_CS(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_cs     (cpu_cs),
        .flush      (flush),
        .rom_ok     (rom_ok),
        .cpu_dout   (cpu_dout),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed no-finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_cs = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait for a request, hold it a cycle, ack, optionally flush in WAIT, then return data.
    task automatic serve(input logic [13:0] exp_addr, input logic [31:0] word,
                         input logic ok_during, input logic do_flush);
        for (int i = 0; i < 20 && !sdram_req; i++) step();
        chk("req_up", 32'(sdram_req), 32'd1);
        chk("req_addr", 32'(sdram_addr), 32'(exp_addr));
        step();
        chk("req_hold", 32'(sdram_req), 32'd1);
        chk("req_addr_hold", 32'(sdram_addr), 32'(exp_addr));
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk("req_drop", 32'(sdram_req), 32'd0);
        if (do_flush) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        step();
        chk("ok_in_wait", 32'(rom_ok), 32'(ok_during));
        sdram_dok  = 1'b1;
        sdram_data = word;
        step();
        sdram_dok = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        do_reset();
        #1;
        chk("rst_ok", 32'(rom_ok), 32'd0);
        chk("rst_dout", 32'(cpu_dout), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);

`ifndef JTFRAME_ROMCACHE_PREFETCH_EN
        // Cold miss
        cpu_cs = 1'b1;
        cpu_addr = 16'h8001;
        #1 chk("cold_ok0", 32'(rom_ok), 32'd0);
        serve(14'h2000, 32'h44332211, 1'b0, 1'b0);
        #1 chk("cold_ok1", 32'(rom_ok), 32'd1);
        chk("cold_dout", 32'(cpu_dout), 32'h22);

        // Sequential hits
        w = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'h8000 + 16'(i);
            #1;
            chk("seq_ok", 32'(rom_ok), 32'd1);
            chk("seq_dout", 32'(cpu_dout), 32'(w[8*i +: 8]));
            chk("seq_noreq", 32'(sdram_req), 32'd0);
            step();
        end

        // LRU eviction
        cpu_addr = 16'h8004;
        #1 chk("lru_miss1", 32'(rom_ok), 32'd0);
        serve(14'h2001, 32'h88776655, 1'b0, 1'b0);
        #1 chk("lru_dout1", 32'(cpu_dout), 32'h55);
        cpu_addr = 16'h8000;
        #1 chk("lru_hit0", 32'(cpu_dout), 32'h11);
        step();
        cpu_addr = 16'h8008;
        #1 chk("lru_miss2", 32'(rom_ok), 32'd0);
        serve(14'h2002, 32'hccbbaa99, 1'b0, 1'b0);
        #1 chk("lru_dout2", 32'(cpu_dout), 32'h99);
        cpu_addr = 16'h8000;
        #1 chk("lru_kept_ok", 32'(rom_ok), 32'd1);
        chk("lru_kept_dout", 32'(cpu_dout), 32'h11);
        cpu_addr = 16'h8004;
        #1 chk("lru_evicted", 32'(rom_ok), 32'd0);
        serve(14'h2001, 32'h88776655, 1'b0, 1'b0);

        // Flush mid-fetch
        cpu_addr = 16'hA000;
        #1;
        serve(14'h2800, 32'hdeadbeef, 1'b0, 1'b1);
        #1 chk("flush_discard", 32'(rom_ok), 32'd0);
        step();
        chk("flush_reissue", 32'(sdram_req), 32'd1);
        chk("flush_readdr", 32'(sdram_addr), 32'h2800);
        serve(14'h2800, 32'h04030201, 1'b0, 1'b0);
        #1 chk("flush_refill", 32'(cpu_dout), 32'h01);
        cpu_addr = 16'h8000;
        #1 chk("flushed_line", 32'(rom_ok), 32'd0);

        // Address change mid-fetch
        cpu_addr = 16'h8001;
        for (int i = 0; i < 20 && !sdram_req; i++) step();
        chk("chg_addr", 32'(sdram_addr), 32'h2000);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        cpu_addr = 16'h9000;
        step();
        #1 chk("chg_ok_wait", 32'(rom_ok), 32'd0);
        sdram_dok = 1'b1;
        sdram_data = 32'h44332211;
        #1 chk("chg_ok_dok", 32'(rom_ok), 32'd0);
        step();
        sdram_dok = 1'b0;
        #1 chk("chg_ok_after", 32'(rom_ok), 32'd0);
        step();
        chk("chg_newreq", 32'(sdram_req), 32'd1);
        chk("chg_newaddr", 32'(sdram_addr), 32'h2400);
        serve(14'h2400, 32'h0d0c0b0a, 1'b0, 1'b0);
        #1 chk("chg_dout", 32'(cpu_dout), 32'h0a);
        cpu_addr = 16'h8001;
        #1 chk("chg_filled_ok", 32'(rom_ok), 32'd1);
        chk("chg_filled_dout", 32'(cpu_dout), 32'h22);

        // ack and dok in the same cycle
        cpu_addr = 16'h8008;
        #1 chk("same_miss", 32'(rom_ok), 32'd0);
        for (int i = 0; i < 20 && !sdram_req; i++) step();
        chk("same_addr", 32'(sdram_addr), 32'h2002);
        sdram_ack = 1'b1;
        sdram_dok = 1'b1;
        sdram_data = 32'h5a6b7c8d;
        step();
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        #1 chk("same_req", 32'(sdram_req), 32'd0);
        chk("same_ok", 32'(rom_ok), 32'd1);
        chk("same_dout", 32'(cpu_dout), 32'h8d);

        // Reset mid-fetch, then a late dok
        cpu_addr = 16'h800C;
        step();
        chk("rmid_req", 32'(sdram_req), 32'd1);
        chk("rmid_addr", 32'(sdram_addr), 32'h2003);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_cs = 1'b0;
        #1 chk("rmid_req0", 32'(sdram_req), 32'd0);
        chk("rmid_addr0", 32'(sdram_addr), 32'd0);
        sdram_dok = 1'b1;
        sdram_data = 32'hffffffff;
        step();
        sdram_dok = 1'b0;
        chk("late_dok_req", 32'(sdram_req), 32'd0);
        cpu_cs = 1'b1;
        cpu_addr = 16'h800C;
        #1 chk("late_dok_ok", 32'(rom_ok), 32'd0);
        serve(14'h2003, 32'h13121110, 1'b0, 1'b0);
        #1 chk("late_refill", 32'(cpu_dout), 32'h10);
`endif

        // Top-of-space word
        do_reset();
        cpu_cs = 1'b1;
        cpu_addr = 16'hFFFC;
        #1 chk("top_miss", 32'(rom_ok), 32'd0);
        serve(14'h3FFF, 32'hdeadbeef, 1'b0, 1'b0);
        #1 chk("top_ok", 32'(rom_ok), 32'd1);
        chk("top_dout", 32'(cpu_dout), 32'hef);
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
        step();
        chk("pf_req", 32'(sdram_req), 32'd1);
        chk("pf_wrap", 32'(sdram_addr), 32'h0000);
        serve(14'h0000, 32'h76543210, 1'b1, 1'b0);
        cpu_addr = 16'h0000;
        #1 chk("pf_hit", 32'(rom_ok), 32'd1);
        chk("pf_dout", 32'(cpu_dout), 32'h10);
        chk("pf_noreq", 32'(sdram_req), 32'd0);
        repeat (3) step();
        chk("pf_no_chain", 32'(sdram_req), 32'd0);
`else
        repeat (3) step();
        chk("no_prefetch", 32'(sdram_req), 32'd0);
        cpu_addr = 16'h0000;
        #1 chk("no_pf_miss", 32'(rom_ok), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
